// File: rtl/watch_mode_ctrl.sv
// Watch mode controller: button routing, mode select, alarm arbitration.
// Optional idle auto-return to clock mode under WATCH_AUTO_RETURN_EN.
module watch_mode_ctrl #(
  parameter int NUM_MODES   = 7,
  parameter int RING_CYCLES = 30000,
  parameter int IDLE_CYCLES = 60000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           btn_i,
  input  logic [NUM_MODES-1:0] norm_i,
  input  logic [NUM_MODES-1:0] alarm_req_i,
  output logic [NUM_MODES-1:0] btn_en_o,
  output logic [5:0]           btn_pulse_o,
  output logic [2:0]           mode_o,
  output logic [NUM_MODES-1:0] ack_o,
  output logic [7:0]           o_m,
  output logic                 alarm
);

  localparam int RW = $clog2(RING_CYCLES + 1);
  localparam logic [RW-1:0] RING_END = RW'(RING_CYCLES - 1);
  localparam logic [2:0] LAST = 3'(NUM_MODES - 1);

  localparam int B_ESC   = 5;
  localparam int B_ENTER = 4;
  localparam int B_RIGHT = 3;
  localparam int B_LEFT  = 2;

  typedef enum logic [1:0] {
    S_NAV  = 2'd0,
    S_ACT  = 2'd1,
    S_RING = 2'd2
  } state_t;

  state_t               state_q, state_d;
  state_t               sv_state_q, sv_state_d;
  logic [2:0]           mode_q, mode_d;
  logic [2:0]           sv_mode_q, sv_mode_d;
  logic [2:0]           src_q, src_d;
  logic [RW-1:0]        ring_cnt_q, ring_cnt_d;
  logic [NUM_MODES-1:0] mask_q, mask_d;
  logic [NUM_MODES-1:0] ack_q, ack_d;
  logic [5:0]           pulse_q, pulse_d;
  logic [5:0]           btn_prev_q;
  logic                 alarm_q, alarm_d;

`ifdef WATCH_AUTO_RETURN_EN
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_END = IW'(IDLE_CYCLES - 1);
  logic [IW-1:0] idle_q, idle_d;
`endif

  logic [5:0]           rise;
  logic [5:0]           ev;
  logic                 ev_any;
  logic [NUM_MODES-1:0] pending;
  logic [2:0]           pend_src;
  logic [NUM_MODES-1:0] mode_oh;

  assign rise    = btn_i & ~btn_prev_q;
  assign ev_any  = |ev;
  assign pending = alarm_req_i & ~mask_q;
  assign mode_oh = NUM_MODES'(1) << mode_q;

  // One event per cycle; lower-priority simultaneous rises are dropped.
  always_comb begin
    ev = '0;
    priority case (1'b1)
      rise[5]: ev[5] = 1'b1;
      rise[4]: ev[4] = 1'b1;
      rise[3]: ev[3] = 1'b1;
      rise[2]: ev[2] = 1'b1;
      rise[1]: ev[1] = 1'b1;
      rise[0]: ev[0] = 1'b1;
      default: ev = '0;
    endcase
  end

  always_comb begin
    pend_src = '0;
    for (int i = NUM_MODES - 1; i >= 0; i--) begin
      if (pending[i]) pend_src = 3'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    sv_state_d = sv_state_q;
    mode_d     = mode_q;
    sv_mode_d  = sv_mode_q;
    src_d      = src_q;
    ring_cnt_d = ring_cnt_q;
    mask_d     = mask_q & alarm_req_i;
    ack_d      = '0;
    pulse_d    = '0;
    alarm_d    = alarm_q;
`ifdef WATCH_AUTO_RETURN_EN
    idle_d     = idle_q;
`endif
    case (state_q)
      S_RING: begin
`ifdef WATCH_AUTO_RETURN_EN
        idle_d = '0;
`endif
        if (!alarm_req_i[src_q] || ev_any || ring_cnt_q == RING_END) begin
          if (alarm_req_i[src_q]) begin
            ack_d[src_q]  = 1'b1;
            mask_d[src_q] = 1'b1;
          end
          state_d    = sv_state_q;
          mode_d     = sv_mode_q;
          alarm_d    = 1'b0;
          ring_cnt_d = '0;
        end else begin
          ring_cnt_d = ring_cnt_q + 1'b1;
        end
      end
      default: begin
        if (|pending) begin
          sv_state_d = state_q;
          sv_mode_d  = mode_q;
          state_d    = S_RING;
          mode_d     = pend_src;
          src_d      = pend_src;
          alarm_d    = 1'b1;
          ring_cnt_d = '0;
`ifdef WATCH_AUTO_RETURN_EN
          idle_d     = '0;
`endif
        end else begin
          if (state_q == S_NAV) begin
            if (ev[B_ENTER]) begin
              state_d = S_ACT;
            end else if (ev[B_RIGHT]) begin
              mode_d = (mode_q == LAST) ? 3'd0 : mode_q + 3'd1;
            end else if (ev[B_LEFT]) begin
              mode_d = (mode_q == 3'd0) ? LAST : mode_q - 3'd1;
            end
          end else begin
            if (ev[B_ESC] && norm_i[mode_q]) state_d = S_NAV;
            else pulse_d = ev;
          end
`ifdef WATCH_AUTO_RETURN_EN
          if (ev_any || !norm_i[mode_q]) begin
            idle_d = '0;
          end else if (idle_q == IDLE_END) begin
            idle_d  = '0;
            state_d = S_NAV;
            mode_d  = 3'd1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_NAV;
      sv_state_q <= S_NAV;
      mode_q     <= 3'd1;
      sv_mode_q  <= 3'd1;
      src_q      <= '0;
      ring_cnt_q <= '0;
      mask_q     <= '0;
      ack_q      <= '0;
      pulse_q    <= '0;
      btn_prev_q <= '0;
      alarm_q    <= 1'b0;
`ifdef WATCH_AUTO_RETURN_EN
      idle_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sv_state_q <= sv_state_d;
      mode_q     <= mode_d;
      sv_mode_q  <= sv_mode_d;
      src_q      <= src_d;
      ring_cnt_q <= ring_cnt_d;
      mask_q     <= mask_d;
      ack_q      <= ack_d;
      pulse_q    <= pulse_d;
      btn_prev_q <= btn_i;
      alarm_q    <= alarm_d;
`ifdef WATCH_AUTO_RETURN_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign btn_en_o    = (state_q == S_ACT) ? mode_oh : '0;
  assign btn_pulse_o = pulse_q;
  assign mode_o      = mode_q;
  assign ack_o       = ack_q;
  assign alarm       = alarm_q;
  assign o_m         = {alarm_q, 7'(mode_oh)};

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Directed bench for watch_mode_ctrl (RING_CYCLES=20, IDLE_CYCLES=16).
module tb_watch_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] btn_i;
  logic [6:0] norm_i;
  logic [6:0] alarm_req_i;
  logic [6:0] btn_en_o;
  logic [5:0] btn_pulse_o;
  logic [2:0] mode_o;
  logic [6:0] ack_o;
  logic [7:0] o_m;
  logic       alarm;

  int total = 0;
  int bad   = 0;

  watch_mode_ctrl #(
    .NUM_MODES  (7),
    .RING_CYCLES(20),
    .IDLE_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_i      (btn_i),
    .norm_i     (norm_i),
    .alarm_req_i(alarm_req_i),
    .btn_en_o   (btn_en_o),
    .btn_pulse_o(btn_pulse_o),
    .mode_o     (mode_o),
    .ack_o      (ack_o),
    .o_m        (o_m),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycle so the previous level is low, then a one-cycle press.
  task automatic press(input int k);
    tick();
    btn_i = 6'(1 << k);
    tick();
    btn_i = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_i = '0; norm_i = '1; alarm_req_i = '0;
    tick(); tick();
    total++;
    if (mode_o !== 3'd1) begin bad++; $display("FAIL reset_mode got=%0d exp=1", mode_o); end
    total++;
    if (o_m !== 8'h02) begin bad++; $display("FAIL reset_om got=%h exp=02", o_m); end
    total++;
    if ({btn_en_o, btn_pulse_o, ack_o, alarm} !== '0) begin
      bad++; $display("FAIL reset_outs en=%b pulse=%b ack=%b alarm=%b exp all 0",
                      btn_en_o, btn_pulse_o, ack_o, alarm);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nav();
    logic [2:0] exp_r [7] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1};
    for (int i = 0; i < 7; i++) begin
      press(3);
      total++;
      if (mode_o !== exp_r[i] || btn_pulse_o !== 6'b0 || btn_en_o !== 7'b0) begin
        bad++; $display("FAIL nav_right%0d mode=%0d pulse=%b en=%b exp mode=%0d pulse/en 0",
                        i, mode_o, btn_pulse_o, btn_en_o, exp_r[i]);
      end
    end
    press(2);
    total++;
    if (mode_o !== 3'd0) begin bad++; $display("FAIL nav_left_1to0 got=%0d exp=0", mode_o); end
    press(2);
    total++;
    if (mode_o !== 3'd6) begin bad++; $display("FAIL nav_left_wrap got=%0d exp=6", mode_o); end
    press(0); press(1);
    total++;
    if (mode_o !== 3'd6 || btn_pulse_o !== 6'b0 || btn_en_o !== 7'b0) begin
      bad++; $display("FAIL nav_updown mode=%0d pulse=%b en=%b exp 6/0/0",
                      mode_o, btn_pulse_o, btn_en_o);
    end
    press(2); press(2); press(2);
  endtask

  task automatic test_active();
    press(4);
    total++;
    if (btn_en_o !== 7'b0001000 || btn_pulse_o !== 6'b0) begin
      bad++; $display("FAIL act_enter en=%b pulse=%b exp 0001000/000000", btn_en_o, btn_pulse_o);
    end
    press(0);
    total++;
    if (btn_pulse_o !== 6'b000001 || btn_en_o !== 7'b0001000) begin
      bad++; $display("FAIL act_up pulse=%b en=%b exp 000001/0001000", btn_pulse_o, btn_en_o);
    end
    tick();
    total++;
    if (btn_pulse_o !== 6'b0) begin bad++; $display("FAIL act_up_width pulse=%b exp 0", btn_pulse_o); end
    press(5);
    total++;
    if (btn_en_o !== 7'b0 || btn_pulse_o !== 6'b0) begin
      bad++; $display("FAIL act_esc_exit en=%b pulse=%b exp 0/0", btn_en_o, btn_pulse_o);
    end
    press(2); press(2); press(2);
    total++;
    if (mode_o !== 3'd0) begin bad++; $display("FAIL act_to_mode0 got=%0d exp=0", mode_o); end
  endtask

  task automatic test_esc_forward();
    norm_i = 7'b1111110;
    press(4);
    press(5);
    total++;
    if (btn_pulse_o !== 6'b100000 || btn_en_o !== 7'b0000001) begin
      bad++; $display("FAIL esc_fwd pulse=%b en=%b exp 100000/0000001", btn_pulse_o, btn_en_o);
    end
    tick();
    total++;
    if (btn_pulse_o !== 6'b0) begin bad++; $display("FAIL esc_fwd_width pulse=%b exp 0", btn_pulse_o); end
    btn_i = 6'b100001;
    tick();
    btn_i = '0;
    total++;
    if (btn_pulse_o !== 6'b100000) begin
      bad++; $display("FAIL esc_up_prio pulse=%b exp 100000", btn_pulse_o);
    end
    norm_i = '1;
    press(5);
    total++;
    if (btn_en_o !== 7'b0 || btn_pulse_o !== 6'b0) begin
      bad++; $display("FAIL esc_norm_exit en=%b pulse=%b exp 0/0", btn_en_o, btn_pulse_o);
    end
  endtask

  task automatic test_back_to_back();
    press(3); press(3); press(3); press(4);
    alarm_req_i = 7'b0010100;
    tick();
    total++;
    if (alarm !== 1'b1 || mode_o !== 3'd2 || o_m !== 8'h84 || btn_en_o !== 7'b0) begin
      bad++; $display("FAIL ring1 alarm=%b mode=%0d om=%h en=%b exp 1/2/84/0",
                      alarm, mode_o, o_m, btn_en_o);
    end
    press(1);
    total++;
    if (ack_o !== 7'b0000100 || alarm !== 1'b0 || mode_o !== 3'd3 || btn_pulse_o !== 6'b0) begin
      bad++; $display("FAIL ack1 ack=%b alarm=%b mode=%0d pulse=%b exp 0000100/0/3/0",
                      ack_o, alarm, mode_o, btn_pulse_o);
    end
    tick();
    total++;
    if (alarm !== 1'b1 || mode_o !== 3'd4 || ack_o !== 7'b0 || o_m !== 8'h90) begin
      bad++; $display("FAIL ring2 alarm=%b mode=%0d ack=%b om=%h exp 1/4/0/90",
                      alarm, mode_o, ack_o, o_m);
    end
    press(0);
    total++;
    if (ack_o !== 7'b0010000 || mode_o !== 3'd3 || btn_en_o !== 7'b0001000) begin
      bad++; $display("FAIL ack2 ack=%b mode=%0d en=%b exp 0010000/3/0001000",
                      ack_o, mode_o, btn_en_o);
    end
    tick();
    total++;
    if (alarm !== 1'b0 || ack_o !== 7'b0 || btn_en_o !== 7'b0001000 || btn_pulse_o !== 6'b0) begin
      bad++; $display("FAIL masked alarm=%b ack=%b en=%b pulse=%b exp 0/0/0001000/0",
                      alarm, ack_o, btn_en_o, btn_pulse_o);
    end
  endtask

  task automatic test_ring_timeout();
    int n;
    alarm_req_i = '0;
    tick();
    alarm_req_i = 7'b0010000;
    tick();
    n = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (alarm !== 1'b1) break;
      n++;
    end
    total++;
    if (n !== 20) begin bad++; $display("FAIL ring_len got=%0d exp=20", n); end
    total++;
    if (ack_o !== 7'b0010000 || mode_o !== 3'd3) begin
      bad++; $display("FAIL timeout_ack ack=%b mode=%0d exp 0010000/3", ack_o, mode_o);
    end
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (alarm !== 1'b0) n++;
    end
    total++;
    if (n !== 0) begin bad++; $display("FAIL no_retrigger ring_cycles=%0d exp=0", n); end
    alarm_req_i = '0;
    tick();
    alarm_req_i = 7'b0010000;
    tick();
    total++;
    if (alarm !== 1'b1 || mode_o !== 3'd4) begin
      bad++; $display("FAIL rering alarm=%b mode=%0d exp 1/4", alarm, mode_o);
    end
    alarm_req_i = '0;
    tick();
    total++;
    if (alarm !== 1'b0 || ack_o !== 7'b0 || mode_o !== 3'd3 || btn_en_o !== 7'b0001000) begin
      bad++; $display("FAIL req_drop alarm=%b ack=%b mode=%0d en=%b exp 0/0/3/0001000",
                      alarm, ack_o, mode_o, btn_en_o);
    end
  endtask

  task automatic test_reset_mid_ring();
    alarm_req_i = 7'b0000010;
    tick();
    total++;
    if (alarm !== 1'b1 || mode_o !== 3'd1) begin
      bad++; $display("FAIL ring_pre_reset alarm=%b mode=%0d exp 1/1", alarm, mode_o);
    end
    rst_n = 1'b0;
    alarm_req_i = '0;
    tick();
    total++;
    if (alarm !== 1'b0 || o_m !== 8'h02 || btn_en_o !== 7'b0) begin
      bad++; $display("FAIL reset_mid_ring alarm=%b om=%h en=%b exp 0/02/0", alarm, o_m, btn_en_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_idle();
    int stuck;
    norm_i = '1;
    press(3); press(3); press(3); press(3);
    total++;
    if (mode_o !== 3'd5) begin bad++; $display("FAIL idle_setup got=%0d exp=5", mode_o); end
`ifdef WATCH_AUTO_RETURN_EN
    stuck = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (mode_o !== 3'd5) stuck++;
    end
    total++;
    if (stuck !== 0) begin bad++; $display("FAIL idle_early changed_cycles=%0d exp=0", stuck); end
    tick();
    total++;
    if (mode_o !== 3'd1) begin bad++; $display("FAIL idle_return got=%0d exp=1", mode_o); end
    norm_i = 7'b1011111;
    press(3); press(3); press(3); press(3);
`endif
    stuck = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mode_o !== 3'd5) stuck++;
    end
    total++;
    if (stuck !== 0) begin bad++; $display("FAIL idle_hold changed_cycles=%0d exp=0", stuck); end
    norm_i = '1;
  endtask

  initial begin
    test_reset();
    test_nav();
    test_active();
    test_esc_forward();
    test_back_to_back();
    test_ring_timeout();
    test_reset_mid_ring();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
